// File: rtl/sram_controller_pkg.sv
// Shared widths, memory map and FSM encoding for the 16-bit SRAM controller.
// Optional statistics counters are enabled with the SRAM_CTRL_STATS_EN macro.
package sram_controller_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int MEM_BASE        = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // SRAM word index of a CPU byte address; the half-word select is appended as LSB.
  function automatic logic [SRAM_ADDR_WIDTH-2:0] word_base(
    input logic [WORD_WIDTH-1:0] address,
    input logic [WORD_WIDTH-1:0] mem_base
  );
    return (SRAM_ADDR_WIDTH-1)'((address - mem_base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus between the pipeline and the SRAM controller.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                  wr_en;
  logic                  rd_en;
  logic [WORD_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] write_data;
  logic [WORD_WIDTH-1:0] read_data;
  logic                  ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Per-half-word hold counter: cleared by start_i, flags last_o on the final hold cycle.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= '0;
    end else if (en_i && !last_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Sequences each 32-bit load/store as two half-word accesses on a 16-bit async SRAM.
// Define SRAM_CTRL_STATS_EN to add access_count / stall_count outputs.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_controller_if.slave           bus,
  inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0]                access_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int HW = SRAM_DATA_WIDTH;

  state_e                     state_q;
  logic                       store_q;
  logic [SRAM_ADDR_WIDTH-2:0] base_q;
  logic [WORD_WIDTH-1:0]      wdata_q;
  logic [WORD_WIDTH-1:0]      rdata_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic                       we_n_q;
  logic [HW-1:0]              dq_q;
  logic                       dq_oe_q;

  logic req;
  logic ready;
  logic last;
  logic cnt_start;
  logic cnt_en;

  assign req       = bus.rd_en | bus.wr_en;
  assign cnt_start = ((state_q == ST_IDLE) && req) || ((state_q == ST_LOW) && last);
  assign cnt_en    = (state_q == ST_LOW) || (state_q == ST_HIGH);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .start_i(cnt_start),
    .en_i   (cnt_en),
    .last_o (last)
  );

  // Bus outputs are registered so WE_N and DQ change only on state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_LOW;
            store_q <= bus.wr_en;
            base_q  <= word_base(bus.address, WORD_WIDTH'(MEM_BASE));
            wdata_q <= bus.write_data;
            addr_q  <= {word_base(bus.address, WORD_WIDTH'(MEM_BASE)), 1'b0};
            we_n_q  <= ~bus.wr_en;
            dq_q    <= bus.write_data[HW-1:0];
            dq_oe_q <= bus.wr_en;
          end
        end
        ST_LOW: begin
          if (last) begin
            if (!store_q) rdata_q[HW-1:0] <= SRAM_DQ;
            state_q <= ST_HIGH;
            addr_q  <= {base_q, 1'b1};
            dq_q    <= wdata_q[2*HW-1:HW];
          end
        end
        ST_HIGH: begin
          if (last) begin
            if (!store_q) rdata_q[2*HW-1:HW] <= SRAM_DQ;
            state_q <= ST_DONE;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // In IDLE a fresh request must freeze the pipeline in the same cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_IDLE: ready = ~req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign bus.ready     = ready;
  assign bus.read_data = rdata_q;

  assign SRAM_DQ   = dq_oe_q ? dq_q : {HW{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] access_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      if (state_q == ST_DONE) access_count_q <= access_count_q + 32'd1;
      if (!ready)             stall_count_q  <= stall_count_q + 32'd1;
    end
  end

  assign access_count = access_count_q;
  assign stall_count  = stall_count_q;
`endif

endmodule
